// File: rtl/demux1to4_reg_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer.
package demux1to4_reg_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  localparam logic [SEL_W-1:0] CH0 = 2'd0;
  localparam logic [SEL_W-1:0] CH1 = 2'd1;
  localparam logic [SEL_W-1:0] CH2 = 2'd2;
  localparam logic [SEL_W-1:0] CH3 = 2'd3;

  function automatic logic [NUM_CH-1:0] dest_onehot(input logic [SEL_W-1:0] dest);
    return NUM_CH'(1) << dest;
  endfunction

endpackage

// File: rtl/demux1to4_reg_chan_reg.sv
// One-entry holding register with valid/ready handshake and accepted-beat counter.
module demux_chan_reg #(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [DW-1:0]    i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [DW-1:0]    o_data,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_free
);

  logic             r_valid;
  logic [DW-1:0]    r_data;
  logic [CNT_W-1:0] r_cnt;

  // A load always wins over a drain, so simultaneous drain+fill stays FULL.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_cnt   <= r_cnt + 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 demultiplexer; define DEMUX_ROUND_ROBIN_EN to route by an
// internal round-robin pointer instead of sel.
module demux1to4_reg
  import demux1to4_reg_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [NUM_CH-1:0]     out_valid,
  input  logic [NUM_CH-1:0]     out_ready,
  output logic [NUM_CH*DW-1:0]  out_data,
  output logic [NUM_CH*CNT_W-1:0] beat_cnt
);

  logic [SEL_W-1:0]  w_dest;
  logic [NUM_CH-1:0] w_free;
  logic [NUM_CH-1:0] w_load;
  logic              w_accept;

`ifdef DEMUX_ROUND_ROBIN_EN
  logic [SEL_W-1:0] r_ptr;

  // Pointer advances only on accept; a stalled target is never skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= CH0;
    end else if (w_accept) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign w_dest = r_ptr;
`else
  assign w_dest = sel;
`endif

  assign in_ready = !rst && w_free[w_dest];
  assign w_accept = in_valid && in_ready;
  assign w_load   = {NUM_CH{w_accept}} & dest_onehot(w_dest);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_chan_reg #(
      .DW    (DW),
      .CNT_W (CNT_W)
    ) u_chan (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_load  (w_load[k]),
      .i_data  (in_data),
      .i_ready (out_ready[k]),
      .o_valid (out_valid[k]),
      .o_data  (out_data[k*DW +: DW]),
      .o_cnt   (beat_cnt[k*CNT_W +: CNT_W]),
      .o_free  (w_free[k])
    );
  end

endmodule

// File: tb/tb_demux1to4_reg.sv
// Self-checking bench for demux1to4_reg: directed cases plus random traffic
// against a per-channel behavioural model.
module tb_demux1to4_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [31:0] beat_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_data [4];
  logic [7:0] m_cnt  [4];
  logic       m_valid[4];
  logic [1:0] m_ptr;
  logic       last_ready;

  always #5 clk = ~clk;

  demux1to4_reg #(
    .DW    (8),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .beat_cnt  (beat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs in the low phase, check in_ready, advance the
  // model at the edge, then check all registered outputs.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [7:0] d,
                       input logic [3:0] r, input logic rs);
    int          dest;
    logic        exp_ready;
    logic [3:0]  ev;
    logic [31:0] ed, ec;
    in_valid  = v;
    sel       = s;
    in_data   = d;
    out_ready = r;
    rst       = rs;
    #1;
`ifdef DEMUX_ROUND_ROBIN_EN
    dest = int'(m_ptr);
`else
    dest = int'(s);
`endif
    exp_ready = !rs && (!m_valid[dest] || r[dest]);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    last_ready = in_ready;
    @(posedge clk);
    if (rs) begin
      for (int k = 0; k < 4; k++) begin
        m_valid[k] = 1'b0;
        m_data[k]  = 8'h00;
        m_cnt[k]   = 8'h00;
      end
      m_ptr = 2'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (v && exp_ready && dest == k) begin
          m_valid[k] = 1'b1;
          m_data[k]  = d;
          m_cnt[k]   = m_cnt[k] + 8'd1;
        end else if (m_valid[k] && r[k]) begin
          m_valid[k] = 1'b0;
        end
      end
      if (v && exp_ready) m_ptr = m_ptr + 2'd1;
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      ev[k]         = m_valid[k];
      ed[k*8 +: 8]  = m_data[k];
      ec[k*8 +: 8]  = m_cnt[k];
    end
    chk("out_valid", {28'd0, out_valid}, {28'd0, ev});
    chk("out_data", out_data, ed);
    chk("beat_cnt", beat_cnt, ec);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = 8'h00;
      m_cnt[k]   = 8'h00;
    end
    m_ptr      = 2'd0;
    last_ready = 1'b0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    sel        = 2'd0;
    out_ready  = 4'h0;
    @(negedge clk);

    // Reset held with in_valid asserted
    cycle(1'b1, 2'd0, 8'h55, 4'h0, 1'b1);
    cycle(1'b1, 2'd0, 8'h55, 4'h0, 1'b1);
    chk("rst_ready", {31'd0, last_ready}, 32'd0);
    chk("rst_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_cnt", beat_cnt, 32'd0);

`ifndef DEMUX_ROUND_ROBIN_EN
    // Routing to channel 2
    cycle(1'b1, 2'd2, 8'hA5, 4'h0, 1'b0);
    chk("post_rst_ready", {31'd0, last_ready}, 32'd1);
    chk("route_valid", {28'd0, out_valid}, 32'h4);
    chk("route_data", {24'd0, out_data[23:16]}, 32'hA5);
    chk("route_cnt", {24'd0, beat_cnt[23:16]}, 32'd1);

    // Backpressure on channel 1 does not block channel 3
    cycle(1'b1, 2'd1, 8'h33, 4'h0, 1'b0);
    cycle(1'b1, 2'd1, 8'h44, 4'h0, 1'b0);
    chk("bp_stall", {31'd0, last_ready}, 32'd0);
    chk("bp_hold", {24'd0, out_data[15:8]}, 32'h33);
    cycle(1'b1, 2'd3, 8'h77, 4'h0, 1'b0);
    chk("bp_other_ready", {31'd0, last_ready}, 32'd1);
    chk("bp_other_data", {24'd0, out_data[31:24]}, 32'h77);

    // Simultaneous drain and fill on channel 0
    cycle(1'b0, 2'd0, 8'h00, 4'h0, 1'b1);
    cycle(1'b1, 2'd0, 8'h11, 4'h0, 1'b0);
    cycle(1'b1, 2'd0, 8'h22, 4'h1, 1'b0);
    chk("sdf_valid", {31'd0, out_valid[0]}, 32'd1);
    chk("sdf_data", {24'd0, out_data[7:0]}, 32'h22);
    chk("sdf_cnt", {24'd0, beat_cnt[7:0]}, 32'd2);

    // 256 back-to-back beats to channel 3 wrap its counter
    cycle(1'b0, 2'd0, 8'h00, 4'h0, 1'b1);
    for (int i = 0; i < 256; i++) cycle(1'b1, 2'd3, 8'(i), 4'h8, 1'b0);
    chk("wrap_cnt", {24'd0, beat_cnt[31:24]}, 32'd0);
    chk("wrap_last", {24'd0, out_data[31:24]}, 32'hFF);
`else
    // Round robin ignores sel and stalls on a full target without skipping
    cycle(1'b1, 2'd0, 8'h01, 4'hF, 1'b0);
    chk("rr_ch0", {28'd0, out_valid}, 32'h1);
    cycle(1'b1, 2'd0, 8'h02, 4'hF, 1'b0);
    chk("rr_ch1", {28'd0, out_valid}, 32'h2);
    cycle(1'b1, 2'd0, 8'h03, 4'hB, 1'b0);
    chk("rr_ch2", {24'd0, out_data[23:16]}, 32'h03);
    cycle(1'b1, 2'd0, 8'h04, 4'hB, 1'b0);
    cycle(1'b1, 2'd0, 8'h05, 4'hB, 1'b0);
    chk("rr_wrap", {24'd0, out_data[7:0]}, 32'h05);
    cycle(1'b1, 2'd0, 8'h06, 4'hB, 1'b0);
    cycle(1'b1, 2'd0, 8'h07, 4'hB, 1'b0);
    chk("rr_stall", {31'd0, last_ready}, 32'd0);
    cycle(1'b1, 2'd0, 8'h07, 4'hF, 1'b0);
    chk("rr_release", {24'd0, out_data[23:16]}, 32'h07);
`endif

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 4'($urandom),
            1'($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
